// File: rtl/oam_scanner.sv
// rtl/oam_scanner.sv - Mode-2 OAM search: selects up to MAX_SPRITES sprites overlapping line Y_in.
module oam_scanner #(
    parameter int          TOTAL_SCANLINES = 154,
    parameter int          OAM_ENTRIES     = 40,
    parameter int          MAX_SPRITES     = 10,
    parameter logic [15:0] OAM_BASE        = 16'hFE00,
    localparam int         YW              = $clog2(TOTAL_SCANLINES)
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             tclk_in,
    input  logic                             scan_start_in,
    input  logic [YW-1:0]                    Y_in,
    input  logic                             tall_sprite_mode_in,
    output logic [15:0]                      addr_out,
    output logic                             addr_valid_out,
    input  logic [7:0]                       data_in,
    input  logic                             data_valid_in,
    output logic [MAX_SPRITES-1:0][17:0]     sprite_buffer_out,
    output logic [3:0]                       sprite_count_out,
    output logic                             scan_busy_out,
    output logic                             scan_done_out
);

    typedef enum logic [2:0] {IDLE, REQ_Y, WAIT_Y, REQ_X, WAIT_X, DONE} state_t;

    state_t                          state_q;
    logic [YW-1:0]                   ly_q;
    logic                            tall_q;
    logic [5:0]                      idx_q;
    logic [7:0]                      y_q;
    logic [3:0]                      count_q;
    logic [MAX_SPRITES-1:0][17:0]    buf_q;
    logic [15:0]                     addr_q;
    logic                            valid_q;
    logic                            busy_q;
    logic                            done_q;

    logic [8:0]  ly16_d;
    logic [8:0]  y9_d;
    logic [8:0]  h9_d;
    logic        hit_d;
    logic [3:0]  row_d;
    logic [15:0] base_d;

    // Overlap test is done in 9 bits so y + h and LY + 16 never wrap.
    always_comb begin
        ly16_d = 9'(ly_q) + 9'd16;
        y9_d   = {1'b0, y_q};
        h9_d   = tall_q ? 9'd16 : 9'd8;
        hit_d  = (ly16_d >= y9_d) && (ly16_d < (y9_d + h9_d));
        row_d  = 4'(ly16_d - y9_d);
        base_d = OAM_BASE + {8'd0, idx_q, 2'b00};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            ly_q    <= '0;
            tall_q  <= 1'b0;
            idx_q   <= '0;
            y_q     <= '0;
            count_q <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (scan_start_in) begin
            // Start and abort-restart share one path; an aborted scan never reaches DONE.
            ly_q    <= Y_in;
            tall_q  <= tall_sprite_mode_in;
            idx_q   <= '0;
            count_q <= '0;
            buf_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= REQ_Y;
        end else begin
            case (state_q)
                IDLE: begin
                end
                REQ_Y: begin
                    if (tclk_in) begin
                        addr_q  <= base_d;
                        valid_q <= 1'b1;
                        state_q <= WAIT_Y;
                    end
                end
                WAIT_Y: begin
                    if (data_valid_in) begin
                        y_q     <= data_in;
                        valid_q <= 1'b0;
                        state_q <= REQ_X;
                    end
                end
                REQ_X: begin
                    if (tclk_in) begin
                        addr_q  <= base_d + 16'd1;
                        valid_q <= 1'b1;
                        state_q <= WAIT_X;
                    end
                end
                WAIT_X: begin
                    if (data_valid_in) begin
                        valid_q <= 1'b0;
                        if (hit_d && (count_q < 4'(MAX_SPRITES))) begin
                            buf_q[count_q] <= {idx_q, data_in, row_d};
                            count_q        <= count_q + 4'd1;
                        end
                        if (idx_q == 6'(OAM_ENTRIES - 1)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + 6'd1;
                            state_q <= REQ_Y;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr_out          = addr_q;
    assign addr_valid_out    = valid_q;
    assign sprite_buffer_out = buf_q;
    assign sprite_count_out  = count_q;
    assign scan_busy_out     = busy_q;
    assign scan_done_out     = done_q;

endmodule

// File: tb/tb_oam_scanner.sv
// tb/tb_oam_scanner.sv - Directed self-checking bench for oam_scanner.
module tb_oam_scanner;

    logic              clk = 1'b0;
    logic              rst_in;
    logic              tclk_in;
    logic              scan_start_in;
    logic [7:0]        Y_in;
    logic              tall_sprite_mode_in;
    logic [15:0]       addr_out;
    logic              addr_valid_out;
    logic [7:0]        data_in;
    logic              data_valid_in;
    logic [9:0][17:0]  sprite_buffer_out;
    logic [3:0]        sprite_count_out;
    logic              scan_busy_out;
    logic              scan_done_out;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  oam [0:159];
    int          wait_states = 0;
    int          wcnt = 0;
    logic [1:0]  tdiv = 2'd0;
    logic [15:0] off;

    int          done_total = 0;
    int          tclk_total = 0;
    int          read_total = 0;
    int          unstable_total = 0;
    logic [15:0] last_addr = 16'd0;
    logic        prev_valid = 1'b0;
    logic [15:0] prev_addr = 16'd0;

    always #5 clk = ~clk;

    oam_scanner dut (
        .clk_in              (clk),
        .rst_in              (rst_in),
        .tclk_in             (tclk_in),
        .scan_start_in       (scan_start_in),
        .Y_in                (Y_in),
        .tall_sprite_mode_in (tall_sprite_mode_in),
        .addr_out            (addr_out),
        .addr_valid_out      (addr_valid_out),
        .data_in             (data_in),
        .data_valid_in       (data_valid_in),
        .sprite_buffer_out   (sprite_buffer_out),
        .sprite_count_out    (sprite_count_out),
        .scan_busy_out       (scan_busy_out),
        .scan_done_out       (scan_done_out)
    );

    assign tclk_in       = (tdiv == 2'd3);
    assign off           = addr_out - 16'hFE00;
    assign data_in       = (off < 16'd160) ? oam[off[7:0]] : 8'd0;
    assign data_valid_in = addr_valid_out && (wcnt >= wait_states);

    // Memory responder plus event counters, all sampled on pre-edge values.
    always @(posedge clk) begin
        tdiv <= tdiv + 2'd1;
        if (!addr_valid_out || data_valid_in) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (scan_busy_out && tclk_in) tclk_total <= tclk_total + 1;
        if (scan_done_out) done_total <= done_total + 1;
        if (addr_valid_out && data_valid_in) begin
            read_total <= read_total + 1;
            last_addr  <= addr_out;
        end
        if (addr_valid_out && prev_valid && addr_out != prev_addr)
            unstable_total <= unstable_total + 1;
        prev_valid <= addr_valid_out;
        prev_addr  <= addr_out;
    end

    task automatic clear_oam();
        for (int i = 0; i < 160; i++) oam[i] = 8'd0;
    endtask

    task automatic set_sprite(input int idx, input logic [7:0] y, input logic [7:0] x);
        oam[idx*4]     = y;
        oam[idx*4 + 1] = x;
    endtask

    task automatic pulse_start(input logic [7:0] ly, input logic tall);
        @(negedge clk);
        Y_in = ly;
        tall_sprite_mode_in = tall;
        scan_start_in = 1'b1;
        @(negedge clk);
        scan_start_in = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!scan_done_out && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!scan_done_out) begin
            failures++;
            $display("FAIL scan_timeout: done=%0b after %0d cycles, required 1", scan_done_out, n);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({addr_out, addr_valid_out, sprite_count_out, scan_busy_out, scan_done_out} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs: addr=%h v=%b cnt=%0d busy=%b done=%b, required all 0",
                     addr_out, addr_valid_out, sprite_count_out, scan_busy_out, scan_done_out);
        end
        checks++;
        if (sprite_buffer_out !== '0) begin
            failures++;
            $display("FAIL reset_buffer: %h, required 0", sprite_buffer_out);
        end
        rst_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_oam();
        int t0, r0, d0;
        clear_oam();
        t0 = tclk_total; r0 = read_total; d0 = done_total;
        pulse_start(8'd0, 1'b0);
        wait_done();
        checks++;
        if (tclk_total - t0 !== 80) begin
            failures++;
            $display("FAIL zero_tclk: %0d strobes, required 80", tclk_total - t0);
        end
        checks++;
        if (read_total - r0 !== 80) begin
            failures++;
            $display("FAIL zero_reads: %0d, required 80", read_total - r0);
        end
        checks++;
        if (sprite_count_out !== 4'd0 || sprite_buffer_out !== '0) begin
            failures++;
            $display("FAIL zero_result: cnt=%0d buf=%h, required 0", sprite_count_out, sprite_buffer_out);
        end
        checks++;
        if (done_total - d0 !== 1) begin
            failures++;
            $display("FAIL zero_done: %0d pulses, required 1", done_total - d0);
        end
    endtask

    task automatic check_two_hits(input string tag);
        logic [17:0] e0, e1;
        e0 = {6'd3, 8'd20, 4'd0};
        e1 = {6'd7, 8'd40, 4'd6};
        checks++;
        if (sprite_count_out !== 4'd2) begin
            failures++;
            $display("FAIL %s_count: %0d, required 2", tag, sprite_count_out);
        end
        checks++;
        if (sprite_buffer_out[0] !== e0 || sprite_buffer_out[1] !== e1) begin
            failures++;
            $display("FAIL %s_entries: %h %h, required %h %h", tag,
                     sprite_buffer_out[0], sprite_buffer_out[1], e0, e1);
        end
    endtask

    task automatic test_two_hits();
        int d0;
        clear_oam();
        set_sprite(3, 8'd16, 8'd20);
        set_sprite(7, 8'd10, 8'd40);
        d0 = done_total;
        pulse_start(8'd0, 1'b0);
        wait_done();
        check_two_hits("two");
        checks++;
        if (done_total - d0 !== 1) begin
            failures++;
            $display("FAIL two_done: %0d pulses, required 1", done_total - d0);
        end
    endtask

    task automatic test_tall();
        logic [17:0] e0;
        e0 = {6'd0, 8'd8, 4'd11};
        clear_oam();
        set_sprite(0, 8'd10, 8'd8);
        pulse_start(8'd5, 1'b1);
        wait_done();
        checks++;
        if (sprite_count_out !== 4'd1 || sprite_buffer_out[0] !== e0) begin
            failures++;
            $display("FAIL tall_hit: cnt=%0d e0=%h, required 1 %h", sprite_count_out, sprite_buffer_out[0], e0);
        end
        pulse_start(8'd5, 1'b0);
        wait_done();
        checks++;
        if (sprite_count_out !== 4'd0) begin
            failures++;
            $display("FAIL short_miss: cnt=%0d, required 0", sprite_count_out);
        end
    endtask

    task automatic test_full();
        int r0;
        logic [17:0] e;
        clear_oam();
        for (int i = 0; i < 40; i++) set_sprite(i, 8'd16, 8'(i));
        r0 = read_total;
        pulse_start(8'd0, 1'b0);
        wait_done();
        checks++;
        if (sprite_count_out !== 4'd10) begin
            failures++;
            $display("FAIL full_count: %0d, required 10", sprite_count_out);
        end
        for (int i = 0; i < 10; i++) begin
            e = {6'(i), 8'(i), 4'd0};
            checks++;
            if (sprite_buffer_out[i] !== e) begin
                failures++;
                $display("FAIL full_entry%0d: %h, required %h", i, sprite_buffer_out[i], e);
            end
        end
        checks++;
        if (read_total - r0 !== 80 || last_addr !== 16'hFE9D) begin
            failures++;
            $display("FAIL full_reads: reads=%0d last=%h, required 80 FE9D", read_total - r0, last_addr);
        end
    endtask

    task automatic test_wait_states();
        int r0, u0;
        clear_oam();
        set_sprite(3, 8'd16, 8'd20);
        set_sprite(7, 8'd10, 8'd40);
        wait_states = 3;
        r0 = read_total; u0 = unstable_total;
        pulse_start(8'd0, 1'b0);
        wait_done();
        wait_states = 0;
        check_two_hits("wait");
        checks++;
        if (unstable_total - u0 !== 0 || read_total - r0 !== 80) begin
            failures++;
            $display("FAIL wait_bus: unstable=%0d reads=%0d, required 0 80", unstable_total - u0, read_total - r0);
        end
    endtask

    task automatic test_restart();
        int d0, n;
        logic [17:0] e0;
        e0 = {6'd3, 8'd20, 4'd2};
        clear_oam();
        set_sprite(3, 8'd16, 8'd20);
        set_sprite(7, 8'd10, 8'd40);
        d0 = done_total;
        pulse_start(8'd0, 1'b0);
        n = 0;
        while (!(addr_valid_out && addr_out == 16'hFE44) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(addr_valid_out && addr_out == 16'hFE44)) begin
            failures++;
            $display("FAIL restart_reach17: addr=%h v=%b, required FE44 1", addr_out, addr_valid_out);
        end
        pulse_start(8'd2, 1'b0);
        checks++;
        if (addr_valid_out !== 1'b0 || sprite_count_out !== 4'd0 || scan_busy_out !== 1'b1) begin
            failures++;
            $display("FAIL restart_clear: v=%b cnt=%0d busy=%b, required 0 0 1",
                     addr_valid_out, sprite_count_out, scan_busy_out);
        end
        wait_done();
        checks++;
        if (sprite_count_out !== 4'd1 || sprite_buffer_out[0] !== e0) begin
            failures++;
            $display("FAIL restart_result: cnt=%0d e0=%h, required 1 %h", sprite_count_out, sprite_buffer_out[0], e0);
        end
        checks++;
        if (done_total - d0 !== 1) begin
            failures++;
            $display("FAIL restart_done: %0d pulses, required 1", done_total - d0);
        end
    endtask

    task automatic test_async_reset();
        int d0;
        d0 = done_total;
        pulse_start(8'd0, 1'b0);
        repeat (100) @(negedge clk);
        #1 rst_in = 1'b1;
        #1;
        checks++;
        if ({addr_out, addr_valid_out, sprite_count_out, scan_busy_out, scan_done_out} !== 23'd0
            || sprite_buffer_out !== '0) begin
            failures++;
            $display("FAIL async_reset: addr=%h v=%b cnt=%0d busy=%b buf=%h, required all 0",
                     addr_out, addr_valid_out, sprite_count_out, scan_busy_out, sprite_buffer_out);
        end
        @(negedge clk);
        rst_in = 1'b0;
        repeat (100) @(negedge clk);
        checks++;
        if (done_total - d0 !== 0 || scan_busy_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done: pulses=%0d busy=%b, required 0 0", done_total - d0, scan_busy_out);
        end
        pulse_start(8'd0, 1'b0);
        wait_done();
        check_two_hits("post_reset");
    endtask

    initial begin
        rst_in = 1'b1;
        scan_start_in = 1'b0;
        Y_in = 8'd0;
        tall_sprite_mode_in = 1'b0;
        clear_oam();
        test_reset();
        test_zero_oam();
        test_two_hits();
        test_tall();
        test_full();
        test_wait_states();
        test_restart();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oam_scanner.md
Name: oam_scanner

Overview:
- Mode-2 OAM search stage directly upstream of the pixel FIFO.
- On each scanline start, walks all 40 OAM entries and selects up to 10 sprites that overlap line Y_in.
- Publishes the selected sprites as the 10-entry sprite buffer consumed by the sprite FIFO.
- The sprite FIFO later fetches sprite flags itself.

Parameters:
TOTAL_SCANLINES, 154, number of scanlines; sets Y_in width to $clog2(TOTAL_SCANLINES).
OAM_ENTRIES, 40, number of OAM sprite entries scanned.
MAX_SPRITES, 10, sprite buffer depth (per-line sprite limit).
OAM_BASE, 16'hFE00, base address of OAM.

Ports:
clk_in  input  1  system clock; single clock domain.
rst_in  input  1  asynchronous, active-high reset.
tclk_in  input  1  T-cycle strobe, one clk_in cycle wide.
scan_start_in  input  1  one-cycle pulse: begin scan for line Y_in (mode 2 entry).
Y_in  input  $clog2(TOTAL_SCANLINES)  current line LY; sampled on scan_start_in.
tall_sprite_mode_in  input  1  LCDC[2]; 0 selects 8-line sprites, 1 selects 16-line sprites; sampled on scan_start_in.
addr_out  output  16  OAM byte address.
addr_valid_out  output  1  read request; held until data_valid_in.
data_in  input  8  OAM read data.
data_valid_in  input  1  data_in valid for the outstanding request.
sprite_buffer_out  output  18 x [9:0]  entry = {oam_index[5:0], oam_x[7:0], row[3:0]}.
sprite_count_out  output  4  number of valid entries, 0..10.
scan_busy_out  output  1  high while a scan is in progress.
scan_done_out  output  1  one-cycle pulse when the scan completes.

Behaviour:
- Reset (async, rst_in=1): all outputs 0, all sprite_buffer_out entries 0, state IDLE.
- FSM states: IDLE, REQ_Y, WAIT_Y, REQ_X, WAIT_X, DONE.
- IDLE:
  - scan_start_in latches LY = Y_in and h = tall ? 16 : 8.
  - Clears count and all 10 entries to 0, sets idx = 0, sets scan_busy_out = 1.
  - Next state: REQ_Y.
- REQ_Y:
  - On tclk_in: addr_out = OAM_BASE + 4*idx, addr_valid_out = 1. Next state: WAIT_Y.
- WAIT_Y:
  - Hold addr_out and addr_valid_out until data_valid_in.
  - On data_valid_in: latch y = data_in, drop addr_valid_out. Next state: REQ_X.
- REQ_X:
  - On the next tclk_in: addr_out = OAM_BASE + 4*idx + 1, addr_valid_out = 1. Next state: WAIT_X.
- WAIT_X, on data_valid_in:
  - Drop addr_valid_out.
  - Evaluate the hit in 9-bit arithmetic: ly16 = LY + 16; hit = (ly16 >= y) && (ly16 < y + h).
  - If hit and count < MAX_SPRITES: entry[count] = {idx, data_in, (ly16 - y)[3:0]}; count++.
  - X value does not gate selection: X = 0 is stored; the sprite FIFO discards it.
  - If idx == OAM_ENTRIES-1, next state is DONE; otherwise idx++ and next state is REQ_Y.
- Buffer full (count == 10): remaining entries are still read, so scan timing is data-independent, but nothing further is stored.
- Same-cycle hit and last index: the entry is stored, then the FSM goes to DONE.
- DONE (one cycle):
  - scan_done_out = 1, scan_busy_out = 0. Next state: IDLE.
  - Buffer and count hold their values until the next scan_start_in.
- Nominal latency: 80 tclk_in strobes from scan start to done, with zero-wait memory (2 per entry). Extra memory wait extends this.
- Restart: scan_start_in in any non-IDLE state aborts and restarts (re-latch, clear, idx = 0).
  - scan_done_out is not pulsed for the aborted scan.
  - addr_valid_out drops for at least one cycle.
- Ordering: entries are stored in ascending OAM index order.
- Row field: always < h. Line rendering applies Y-flip, not this block.
- data_valid_in outside WAIT_Y/WAIT_X is ignored.

Test Plan:
- Reset, then scan with LY=0 and OAM all zero: no hits (ly16=16 not < 0+8); 80 tclk to done; count=0; entries=0.
- LY=0, 8-line mode, sprite 3 y=16 x=20, sprite 7 y=10 x=40: count=2; entry0={3,20,0}; entry1={7,40,6}; scan_done_out pulses once.
- LY=5, tall mode, sprite 0 y=10 x=8: ly16=21, row=11, hit. Same OAM in 8-line mode: miss (21 >= 18). count=1 and count=0 respectively.
- All 40 sprites y=16 x=i, LY=0: count=10; entries hold indices 0..9; all 80 reads still occur; done after final read of address FE9D.
- Memory inserts 3 clk wait states per read: addr_out and addr_valid_out held stable until data_valid_in; results identical to the zero-wait run.
- scan_start_in asserted at idx=17 with new LY, and rst_in asserted mid-scan: clean restart with cleared buffer and a single done pulse. Reset forces all outputs to 0 immediately (asynchronous).
